// File: rtl/cache_data_array_pkg.sv
// Shared defaults and refill FSM encoding for the L1 cache data array.
package cache_data_array_pkg;

  localparam int CACHE_WAYS     = 2;
  localparam int CACHE_BANK_NUM = 4;
  localparam int CACHE_DEPTH    = 256;
  localparam int DATA_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DONE   = 2'd2
  } refill_state_e;

  // Select-field width that stays at least one bit for single-entry dimensions.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_data_array_bank_ram.sv
// One bank of one way: synchronous RAM with per-byte write enables and 1-cycle read.
// Writes are registered and commit one cycle later, so a same-address read in that cycle sees old data.
module cache_data_array_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   addr,
  input  logic            rd_en,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data,
  output logic [DW-1:0]   rd_data
);

  logic [DW-1:0]   mem [2**AW];
  logic [AW-1:0]   wr_addr_q;
  logic [DW/8-1:0] wr_be_q;
  logic [DW-1:0]   wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q <= '0;
      wr_be_q   <= '0;
      wr_data_q <= '0;
    end else begin
      wr_addr_q <= addr;
      wr_be_q   <= wr_be;
      wr_data_q <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DW/8; k++) begin
      if (wr_be_q[k]) mem[wr_addr_q][k*8 +: 8] <= wr_data_q[k*8 +: 8];
    end
    if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/cache_data_array.sv
// N-way, M-bank L1 data store: registered lookups, byte-masked stores, beat-wise refill.
// Holds the refill FSM, write-enable decode, store bypass and read-data staging.
module cache_data_array
  import cache_data_array_pkg::*;
#(
  parameter int WAYS   = CACHE_WAYS,
  parameter int BANKS  = CACHE_BANK_NUM,
  parameter int SET_AW = $clog2(CACHE_DEPTH),
  parameter int DW     = DATA_WIDTH,
  localparam int WAY_W  = sel_width(WAYS),
  localparam int BANK_W = sel_width(BANKS),
  localparam int BE_W   = DW / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [SET_AW-1:0]         req_index_i,
  input  logic [BANK_W-1:0]         req_bank_i,
  input  logic [WAY_W-1:0]          req_way_i,
  input  logic [BE_W-1:0]           req_wstrb_i,
  input  logic [DW-1:0]             req_wdata_i,
  output logic                      rd_valid_o,
  output logic [WAYS*BANKS*DW-1:0]  rd_data_o,
  input  logic                      refill_start_i,
  input  logic [WAY_W-1:0]          refill_way_i,
  input  logic [SET_AW-1:0]         refill_index_i,
  input  logic                      beat_valid_i,
  output logic                      beat_ready_o,
  input  logic [DW-1:0]             beat_data_i,
  output logic                      refill_busy_o,
  output logic                      refill_done_o
);

  localparam logic [BANK_W-1:0] LAST_BEAT = BANK_W'(BANKS - 1);

  refill_state_e       state, state_nxt;
  logic [BANK_W-1:0]   beat_cnt;
  logic [WAY_W-1:0]    ref_way;
  logic [SET_AW-1:0]   ref_index;

  logic                read_acc, store_acc, beat_wr;
  logic [SET_AW-1:0]   ram_addr;
  logic [DW-1:0]       ram_wdata;
  logic [BE_W-1:0]     ram_be   [WAYS][BANKS];
  logic [DW-1:0]       ram_dout [WAYS][BANKS];

  logic                byp_valid;
  logic [SET_AW-1:0]   byp_index;
  logic [WAY_W-1:0]    byp_way;
  logic [BANK_W-1:0]   byp_bank;
  logic [BE_W-1:0]     byp_strb;
  logic [DW-1:0]       byp_data;

  logic                mrg_hit;
  logic [WAY_W-1:0]    mrg_way;
  logic [BANK_W-1:0]   mrg_bank;
  logic [BE_W-1:0]     mrg_strb;
  logic [DW-1:0]       mrg_data;

  // A refill start outranks a lookup presented in the same IDLE cycle.
  always_comb begin
    state_nxt     = state;
    req_ready_o   = 1'b0;
    beat_ready_o  = 1'b0;
    refill_busy_o = 1'b0;
    refill_done_o = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = !refill_start_i;
        if (refill_start_i) state_nxt = ST_REFILL;
      end
      ST_REFILL: begin
        beat_ready_o  = 1'b1;
        refill_busy_o = 1'b1;
        if (beat_valid_i && beat_cnt == LAST_BEAT) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        refill_done_o = 1'b1;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign read_acc  = req_valid_i && req_ready_o && (req_wstrb_i == '0);
  assign store_acc = req_valid_i && req_ready_o && (req_wstrb_i != '0);
  assign beat_wr   = (state == ST_REFILL) && beat_valid_i;
  assign ram_addr  = (state == ST_REFILL) ? ref_index : req_index_i;
  assign ram_wdata = beat_wr ? beat_data_i : req_wdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      ref_way   <= '0;
      ref_index <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && refill_start_i) begin
        ref_way   <= refill_way_i;
        ref_index <= refill_index_i;
        beat_cnt  <= '0;
      end else if (beat_wr) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < BANKS; b++) begin
        ram_be[w][b] = '0;
        if (beat_wr && int'(ref_way) == w && int'(beat_cnt) == b)
          ram_be[w][b] = '1;
        else if (store_acc && int'(req_way_i) == w && int'(req_bank_i) == b)
          ram_be[w][b] = req_wstrb_i;
      end
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
      cache_data_array_bank_ram #(.AW(SET_AW), .DW(DW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .addr    (ram_addr),
        .rd_en   (read_acc),
        .wr_be   (ram_be[w][b]),
        .wr_data (ram_wdata),
        .rd_data (ram_dout[w][b])
      );
    end
  end

  // The last store is still in flight inside the RAM for one cycle; a read right
  // behind it snapshots that store so the merged line stays stable while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      byp_valid  <= 1'b0;
      byp_index  <= '0;
      byp_way    <= '0;
      byp_bank   <= '0;
      byp_strb   <= '0;
      byp_data   <= '0;
      mrg_hit    <= 1'b0;
      mrg_way    <= '0;
      mrg_bank   <= '0;
      mrg_strb   <= '0;
      mrg_data   <= '0;
    end else begin
      rd_valid_o <= read_acc;
      byp_valid  <= store_acc;
      if (store_acc) begin
        byp_index <= req_index_i;
        byp_way   <= req_way_i;
        byp_bank  <= req_bank_i;
        byp_strb  <= req_wstrb_i;
        byp_data  <= req_wdata_i;
      end
      if (read_acc) begin
        mrg_hit  <= byp_valid && (byp_index == req_index_i);
        mrg_way  <= byp_way;
        mrg_bank <= byp_bank;
        mrg_strb <= byp_strb;
        mrg_data <= byp_data;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < BANKS; b++) begin
        rd_data_o[(w*BANKS+b)*DW +: DW] = ram_dout[w][b];
        if (mrg_hit && int'(mrg_way) == w && int'(mrg_bank) == b) begin
          for (int k = 0; k < BE_W; k++) begin
            if (mrg_strb[k]) rd_data_o[(w*BANKS+b)*DW + k*8 +: 8] = mrg_data[k*8 +: 8];
          end
        end
      end
    end
  end

endmodule
